// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: groups the write-side strobe, the read-side valid/ready handshake
// and the status flags of the receive FIFO.
//   master : the UART receiver and host side. It drives p_data, data_valid, rd_ready
//            and overflow_clr.
//   slave  : the FIFO. It drives rd_data, rd_valid, level, full, empty, almost_full
//            and overflow.
interface uart_rx_fifo_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
);
    logic [DWIDTH-1:0] p_data;
    logic              data_valid;
    logic [DWIDTH-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [AWIDTH:0]   level;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              overflow;
    logic              overflow_clr;

    modport master (
        output p_data, data_valid, rd_ready, overflow_clr,
        input  rd_data, rd_valid, level, full, empty, almost_full, overflow
    );

    modport slave (
        input  p_data, data_valid, rd_ready, overflow_clr,
        output rd_data, rd_valid, level, full, empty, almost_full, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO that sits behind the UART receiver.
// Each cycle with data_valid high captures p_data. The head word is presented on
// rd_data/rd_valid and is consumed on rd_valid & rd_ready.
//   clk : system clock, rising edge
//   rst : synchronous reset, active-high
//   bus : uart_rx_fifo_if.slave, carrying the data, handshake and status signals
module uart_rx_fifo #(
    parameter int DWIDTH    = 8,
    parameter int AWIDTH    = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);
    localparam int              DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AFULL_L = (AWIDTH+1)'(AFULL_LVL);

    logic [DWIDTH-1:0] mem [DEPTH];
    // Each pointer carries one wrap bit, so full and empty are told apart by the difference.
    logic [AWIDTH:0]   wr_ptr, rd_ptr, lvl;
    logic              push, pop, drop, is_full, is_empty;

    assign lvl      = wr_ptr - rd_ptr;
    assign is_full  = (lvl == DEPTH_L);
    assign is_empty = (lvl == '0);

    assign pop  = ~is_empty & bus.rd_ready;
    // When full, a write still goes in if a pop frees the head slot on the same edge.
    assign push = bus.data_valid & (~is_full | pop);
    assign drop = bus.data_valid & is_full & ~pop;

    assign bus.rd_data     = mem[rd_ptr[AWIDTH-1:0]];
    assign bus.rd_valid    = ~is_empty;
    assign bus.level       = lvl;
    assign bus.full        = is_full;
    assign bus.empty       = is_empty;
    assign bus.almost_full = (lvl >= AFULL_L);

    // The storage array is not reset. Only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr[AWIDTH-1:0]] <= bus.p_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bus.overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            // A new drop takes priority over a clear in the same cycle.
            if (drop)                  bus.overflow <= 1'b1;
            else if (bus.overflow_clr) bus.overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int AFL = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    uart_rx_fifo #(.DWIDTH(DW), .AWIDTH(AW), .AFULL_LVL(AFL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: a queue of bytes plus a sticky overflow bit.
    logic [7:0] q[$];
    bit         m_ovf;
    bit         known;
    int         total, passed, failed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = q.size();
        chk("rd_valid",    32'(bus.rd_valid),    32'(n != 0));
        chk("level",       32'(bus.level),       32'(n));
        chk("empty",       32'(bus.empty),       32'(n == 0));
        chk("full",        32'(bus.full),        32'(n == DEPTH));
        chk("almost_full", 32'(bus.almost_full), 32'(n >= AFL));
        chk("overflow",    32'(bus.overflow),    32'(m_ovf));
        if (n != 0) chk("rd_data", 32'(bus.rd_data), 32'(q[0]));
    endtask

    // One clock cycle. The outputs left by earlier edges are checked at the negedge,
    // then the inputs are driven and the model is advanced for this edge.
    task automatic cyc(input bit r, input bit dv, input logic [7:0] pd, input bit rr, input bit clr);
        bit pop, full_now;
        @(negedge clk);
        if (known) check_outputs();
        rst = r; bus.data_valid = dv; bus.p_data = pd; bus.rd_ready = rr; bus.overflow_clr = clr;
        if (r) begin
            q.delete();
            m_ovf = 1'b0;
            known = 1'b1;
        end else begin
            full_now = (q.size() == DEPTH);
            pop = (q.size() != 0) && rr;
            if (dv && full_now && !pop) m_ovf = 1'b1;
            else if (clr)               m_ovf = 1'b0;
            if (pop) void'(q.pop_front());
            if (dv && (!full_now || pop)) q.push_back(pd);
        end
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; bus.data_valid = 0; bus.p_data = 0; bus.rd_ready = 0; bus.overflow_clr = 0;
        total = 0; passed = 0; failed = 0; known = 0; m_ovf = 0;

        cyc(1, 0, 8'h00, 0, 0);
        cyc(1, 0, 8'h00, 0, 0);

        // Single word written, then read back.
        cyc(0, 1, 8'hA5, 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        cyc(0, 0, 8'h00, 1, 0);   // rd_ready while empty is ignored

        // Fill the FIFO completely.
        for (int i = 0; i < 16; i++) cyc(0, 1, 8'(i), 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
        // Overflow: the dropped word must never be stored.
        cyc(0, 1, 8'hFF, 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
        cyc(0, 1, 8'hFE, 0, 1);   // drop and clear together: overflow stays set
        cyc(0, 0, 8'h00, 0, 1);   // plain clear
        cyc(0, 0, 8'h00, 0, 0);

        // Full FIFO with a write and a pop in the same cycle.
        cyc(0, 1, 8'h55, 1, 0);
        cyc(0, 0, 8'h00, 0, 0);

        // Drain the FIFO.
        for (int i = 0; i < 16; i++) cyc(0, 0, 8'h00, 1, 0);
        cyc(0, 0, 8'h00, 0, 0);

        // Stream 40 words with rd_ready held high, so the pointers wrap.
        for (int i = 0; i < 40; i++) cyc(0, 1, 8'(8'h80 + i), 1, 0);
        cyc(0, 0, 8'h00, 1, 0);
        cyc(0, 0, 8'h00, 0, 0);

        // Reset in the middle of traffic.
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'(8'h30 + i), 0, 0);
        cyc(1, 1, 8'hEE, 1, 0);
        cyc(0, 0, 8'h00, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit r, dv, rr, clr;
            r   = ($urandom_range(0, 99) == 0);
            dv  = ($urandom_range(0, 99) < 60);
            rr  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70));
            clr = ($urandom_range(0, 19) == 0);
            cyc(r, dv, 8'($urandom), rr, clr);
        end
        cyc(0, 0, 8'h00, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
